color_scan_sequencer: RTL and testbench
=======================================

Name: color_scan_sequencer

Overview:
- Controller that sequences a TCS3200-style colour sensor through its four photodiode filter channels: red, blue, green and clear.
- For each channel it drives the filter-select lines, waits a settle time, then measures the sensor output period in 50 MHz clock cycles.
- It publishes one coherent 4-channel result set per scan, with a start/busy/done handshake.
- It sits between the sensor pins and the colour-classification logic, replacing free-running channel rotation driven by the sensor's own edges.

Parameters:
- SETTLE_CYC, 2500, clk_50M cycles to wait after changing S0..S3 before measuring (50 us).
- PERIODS, 4, number of full sensor output periods summed per channel (1..15).
- TIMEOUT_CYC, 500000, maximum clk_50M cycles allowed for one channel's measurement phase (10 ms).
- CNT_W, 21, width of the period counter and result registers. Must satisfy 2^CNT_W-1 >= TIMEOUT_CYC.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- continuous  in  1  when high at end of scan, next scan starts immediately.
- sensor_out  in  1  raw sensor frequency output, asynchronous.
- s0, s1  out  1  frequency scaling select.
- s2, s3  out  1  filter select.
- busy  out  1  high from the cycle after an accepted start until the cycle of the final done with continuous low.
- done  out  1  one-cycle pulse; result set updated in the same cycle.
- red, blue, green, clear  out  CNT_W  summed period counts for the last completed scan.
- ch_timeout  out  4  per-channel timeout flags for the last scan. Bit order: [0]=red, [1]=blue, [2]=green, [3]=clear.

Behaviour:
- Reset (asynchronous, rst_n=0) forces every output and all internal state to reset values immediately:
  - FSM goes to IDLE.
  - s0=s1=s2=s3=0, busy=0, done=0.
  - red/blue/green/clear = 0, ch_timeout = 0.
  - Synchroniser, counters and shadow registers cleared.
  - Reset mid-scan discards partial results.
- Input conditioning:
  - sensor_out passes through a 2-FF synchroniser plus a previous-value register.
  - fall = prev & ~sync. Only fall is used for measurement.
- Pin encoding:
  - While busy: s0=1, s1=0 (20% scaling). In IDLE: s0=s1=0 (sensor power-down).
  - Filter select {s2,s3}: red=00, blue=01, green=11, clear=10.
  - Channel order is red, blue, green, clear. The select lines stay stable for a channel's entire SETTLE and MEASURE phases.
- FSM states:
  - IDLE:
    - If start=1, go to SETTLE with ch=red and busy=1.
    - start while not in IDLE is ignored.
  - SETTLE:
    - Drive the channel's select lines; settle counter counts up.
    - After exactly SETTLE_CYC cycles, go to ARM and clear the timeout counter.
  - ARM:
    - Wait for the first fall. On fall: period counter=0, edge count=0, go to MEASURE.
  - MEASURE:
    - Period counter increments every cycle, saturating at 2^CNT_W-1.
    - Each fall increments edge count. When edge count reaches PERIODS, store the period counter value (including the current cycle) in the channel's shadow register, clear the channel's timeout bit, and go to NEXT.
  - Timeout:
    - The timeout counter runs through ARM and MEASURE.
    - On reaching TIMEOUT_CYC: shadow = all ones, set the channel's timeout bit, go to NEXT.
    - If completion and timeout occur in the same cycle, completion wins.
  - NEXT:
    - If ch != clear: advance ch, go to SETTLE.
    - Else: copy all four shadows and the timeout bits to the outputs, and pulse done for 1 cycle.
      - If continuous=1: go to SETTLE with ch=red; busy stays 1.
      - Else: go to IDLE; busy=0 in the cycle after done.
- Outputs change only at done, so a result set is never mixed across scans. Outputs hold their last values while a new scan runs.
- Nominal scan latency: 4 × (SETTLE_CYC + time to first fall + PERIODS periods) + 4 NEXT cycles + synchroniser delay (3 cycles per edge, a constant offset that cancels in period measurement).

Test Plan:
- Bench uses SETTLE_CYC=4, PERIODS=2, TIMEOUT_CYC=300, CNT_W=21.
- Basic scan:
  - Stimulus: start pulse. Square wave period follows the select lines: 20 cycles for red, 30 for blue, 40 for green, 10 for clear.
  - Required: one done pulse; red=40, blue=60, green=80, clear=20; ch_timeout=0000; busy falls the cycle after done; s0=s1=0 afterwards.
- Pin sequencing:
  - Required: {s2,s3} goes 00, 01, 11, 10 in order; each value is held at least SETTLE_CYC cycles before the first counted edge; s0=1, s1=0 throughout busy.
- Timeout:
  - Stimulus: same as basic scan, but sensor_out held high during green.
  - Required: green=2097151, ch_timeout=0100; red/blue/clear correct; done still pulses.
- Continuous mode:
  - Stimulus: continuous=1, constant 25-cycle period.
  - Required: done pulses repeatedly; every channel=50; busy never drops; outputs stable between done pulses.
- Start while busy, reset mid-measure:
  - Stimulus: extra start pulses during MEASURE.
  - Required: no effect on the scan.
  - Stimulus: rst_n=0 asserted in blue MEASURE.
  - Required: immediately busy=0, done=0, all results=0, s0..s3=0. A fresh start afterwards produces a correct full scan.

Source files
------------

// File: rtl/color_scan_sequencer.sv
// Sequences a TCS3200-style colour sensor through red, blue, green and clear,
// measuring PERIODS output periods per channel and publishing one coherent result set per scan.
module color_scan_sequencer #(
  parameter int SETTLE_CYC  = 2500,
  parameter int PERIODS     = 4,
  parameter int TIMEOUT_CYC = 500000,
  parameter int CNT_W       = 21
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_out,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] clear,
  output logic [3:0]       ch_timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_CLEAR = 2'd3;

  localparam int               SET_W        = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0] SET_ONE      = SET_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [3:0]       PERIODS_L    = 4'(PERIODS);
  localparam logic [3:0]       EDGE_ONE     = 4'd1;

  logic             sync_meta, sync_q, prev_q;
  logic             fall;
  logic [2:0]       state;
  logic [1:0]       ch;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_inc;
  logic [3:0]       edge_cnt;
  logic [CNT_W-1:0] shadow [4];
  logic [3:0]       shadow_to;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= sensor_out;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  assign fall    = prev_q & ~sync_q;
  assign per_inc = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_ONE;

  // 20% scaling while busy, power-down in idle; {s2,s3} = 00,01,11,10 for ch 0..3.
  assign s0 = busy;
  assign s1 = 1'b0;
  assign s2 = busy & ch[1];
  assign s3 = busy & (ch[1] ^ ch[0]);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch         <= CH_RED;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      per_cnt    <= '0;
      edge_cnt   <= '0;
      // NOTE: the four shadows are plain flops, not RAM, so they take the async
      // reset like everything else and a mid-scan reset leaves no stale partials.
      shadow     <= '{default: '0};
      shadow_to  <= '0;
      red        <= '0;
      blue       <= '0;
      green      <= '0;
      clear      <= '0;
      ch_timeout <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy       <= start;
          ch         <= CH_RED;
          settle_cnt <= '0;
          if (start) state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state  <= ST_ARM;
            to_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SET_ONE;
          end
        end

        ST_ARM: begin
          to_cnt <= to_cnt + CNT_ONE;
          if (to_cnt == TIMEOUT_LAST) begin
            shadow[ch]    <= CNT_MAX;
            shadow_to[ch] <= 1'b1;
            state         <= ST_NEXT;
          end else if (fall) begin
            per_cnt  <= '0;
            edge_cnt <= '0;
            state    <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          to_cnt  <= to_cnt + CNT_ONE;
          per_cnt <= per_inc;
          // Completion is tested first so it wins over a coincident timeout.
          if (fall && (edge_cnt + EDGE_ONE == PERIODS_L)) begin
            shadow[ch]    <= per_inc;
            shadow_to[ch] <= 1'b0;
            state         <= ST_NEXT;
          end else begin
            if (fall) edge_cnt <= edge_cnt + EDGE_ONE;
            if (to_cnt == TIMEOUT_LAST) begin
              shadow[ch]    <= CNT_MAX;
              shadow_to[ch] <= 1'b1;
              state         <= ST_NEXT;
            end
          end
        end

        ST_NEXT: begin
          settle_cnt <= '0;
          if (ch != CH_CLEAR) begin
            ch    <= ch + 2'd1;
            state <= ST_SETTLE;
          end else begin
            red        <= shadow[0];
            blue       <= shadow[1];
            green      <= shadow[2];
            clear      <= shadow[3];
            ch_timeout <= shadow_to;
            done       <= 1'b1;
            ch         <= CH_RED;
            state      <= continuous ? ST_SETTLE : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer: a behavioural sensor whose period follows
// the filter-select pins, with hand-computed expected result sets.
module tb_color_scan_sequencer;

  localparam int CNT_W       = 21;
  localparam int SETTLE_CYC  = 4;
  localparam int PERIODS     = 2;
  localparam int TIMEOUT_CYC = 300;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic             clk_50M = 1'b0;
  logic             rst_n;
  logic             start;
  logic             continuous;
  logic             sensor_out;
  logic             s0, s1, s2, s3;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] red, blue, green, clear;
  logic [3:0]       ch_timeout;

  int tests = 0;
  int fails = 0;

  // Sensor model controls
  logic hold_green = 1'b0;
  logic const_mode = 1'b0;
  int   const_per  = 25;
  int   cur_per    = 20;
  int   ph         = 0;

  // Scan log
  logic [1:0] sel_q [$];
  int         hold_q [$];
  int         s01_bad;
  logic [1:0] last_sel;
  bit         have_sel;

  color_scan_sequencer #(
    .SETTLE_CYC (SETTLE_CYC),
    .PERIODS    (PERIODS),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .start     (start),
    .continuous(continuous),
    .sensor_out(sensor_out),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .busy      (busy),
    .done      (done),
    .red       (red),
    .blue      (blue),
    .green     (green),
    .clear     (clear),
    .ch_timeout(ch_timeout)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic int period_for(input logic [1:0] sel);
    if (const_mode) return const_per;
    case (sel)
      2'b00:   return 20;
      2'b01:   return 30;
      2'b11:   return hold_green ? 0 : 40;
      default: return 10;
    endcase
  endfunction

  // Square wave changing on falling clock edges; phase restarts high on a period change.
  always @(negedge clk_50M) begin : sensor_model
    int p;
    p = period_for({s2, s3});
    if (p != cur_per) begin
      cur_per = p;
      ph      = 0;
    end else if (ph >= cur_per - 1) begin
      ph = 0;
    end else begin
      ph = ph + 1;
    end
    sensor_out = (cur_per == 0) ? 1'b1 : (ph < cur_per / 2);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    sel_q.delete();
    hold_q.delete();
    s01_bad  = 0;
    have_sel = 0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) begin
        if (s0 !== 1'b1 || s1 !== 1'b0) s01_bad++;
        if (!have_sel || {s2, s3} != last_sel) begin
          sel_q.push_back({s2, s3});
          hold_q.push_back(1);
          last_sel = {s2, s3};
          have_sel = 1;
        end else begin
          hold_q[$] = hold_q[$] + 1;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    tests++;
    if ({s0, s1, s2, s3} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_pins: got %b expected 0000", {s0, s1, s2, s3});
    end
    tests++;
    if ({red, blue, green, clear} !== '0 || ch_timeout !== 4'b0000) begin
      fails++;
      $display("FAIL reset_results: got %0d %0d %0d %0d to=%b expected all 0",
               red, blue, green, clear, ch_timeout);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_scan();
    bit got;
    clear_log();
    pulse_start();
    wait_done(2000, got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL basic_done: no done within 2000 cycles");
    end
    tests++;
    if (red !== 21'd40 || blue !== 21'd60) begin
      fails++;
      $display("FAIL basic_red_blue: got %0d %0d expected 40 60", red, blue);
    end
    tests++;
    if (green !== 21'd80 || clear !== 21'd20) begin
      fails++;
      $display("FAIL basic_green_clear: got %0d %0d expected 80 20", green, clear);
    end
    tests++;
    if (ch_timeout !== 4'b0000) begin
      fails++;
      $display("FAIL basic_timeout_flags: got %b expected 0000", ch_timeout);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_at_done: got %b expected 1", busy);
    end
    tick();
    tests++;
    if ({done, busy, s0, s1} !== 4'b0000) begin
      fails++;
      $display("FAIL basic_after_done: got done/busy/s0/s1=%b expected 0000",
               {done, busy, s0, s1});
    end
    repeat (5) tick();
  endtask

  task automatic test_pin_sequencing();
    bit         got;
    logic [1:0] exp_sel [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         exp_per [4] = '{20, 30, 40, 10};
    clear_log();
    pulse_start();
    wait_done(2000, got);
    tests++;
    if (!got || sel_q.size() != 4) begin
      fails++;
      $display("FAIL pins_count: got %0d select values (done=%0b) expected 4", sel_q.size(), got);
    end
    for (int i = 0; i < 4 && i < sel_q.size(); i++) begin
      tests++;
      if (sel_q[i] !== exp_sel[i]) begin
        fails++;
        $display("FAIL pins_order_%0d: got %b expected %b", i, sel_q[i], exp_sel[i]);
      end
      tests++;
      if (hold_q[i] < SETTLE_CYC + PERIODS * exp_per[i]) begin
        fails++;
        $display("FAIL pins_hold_%0d: got %0d cycles expected at least %0d",
                 i, hold_q[i], SETTLE_CYC + PERIODS * exp_per[i]);
      end
    end
    tests++;
    if (s01_bad != 0) begin
      fails++;
      $display("FAIL pins_s0_s1: got %0d busy cycles with s0/s1 not 1/0 expected 0", s01_bad);
    end
    repeat (5) tick();
  endtask

  task automatic test_timeout();
    bit got;
    hold_green = 1'b1;
    clear_log();
    pulse_start();
    wait_done(3000, got);
    hold_green = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL timeout_done: no done within 3000 cycles");
    end
    tests++;
    if (green !== ALL_ONES) begin
      fails++;
      $display("FAIL timeout_green: got %0d expected 2097151", green);
    end
    tests++;
    if (ch_timeout !== 4'b0100) begin
      fails++;
      $display("FAIL timeout_flags: got %b expected 0100", ch_timeout);
    end
    tests++;
    if (red !== 21'd40 || blue !== 21'd60 || clear !== 21'd20) begin
      fails++;
      $display("FAIL timeout_others: got %0d %0d %0d expected 40 60 20", red, blue, clear);
    end
    repeat (5) tick();
  endtask

  task automatic test_continuous();
    bit               got;
    int               dones    = 0;
    int               stab_bad = 0;
    int               busy_bad = 0;
    int               val_bad  = 0;
    logic [CNT_W-1:0] er = 21'd40, eb = 21'd60, eg = ALL_ONES, ec = 21'd20;
    logic [3:0]       et = 4'b0100;
    const_mode = 1'b1;
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 3000 && dones < 3; i++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done) begin
        dones++;
        er = 21'd50; eb = 21'd50; eg = 21'd50; ec = 21'd50; et = 4'b0000;
        if (red !== er || blue !== eb || green !== eg || clear !== ec || ch_timeout !== et)
          val_bad++;
      end else if (red !== er || blue !== eb || green !== eg || clear !== ec || ch_timeout !== et) begin
        stab_bad++;
      end
      tick();
    end
    tests++;
    if (dones != 3) begin
      fails++;
      $display("FAIL cont_dones: got %0d done pulses expected 3", dones);
    end
    tests++;
    if (val_bad != 0) begin
      fails++;
      $display("FAIL cont_values: got %0d result sets not all 50 expected 0", val_bad);
    end
    tests++;
    if (stab_bad != 0) begin
      fails++;
      $display("FAIL cont_stable: got %0d cycles with outputs changed outside done expected 0", stab_bad);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL cont_busy: got %0d cycles with busy low expected 0", busy_bad);
    end
    continuous = 1'b0;
    clear_log();
    wait_done(2000, got);
    tick();
    tests++;
    if (!got || busy !== 1'b0 || red !== 21'd50 || clear !== 21'd50) begin
      fails++;
      $display("FAIL cont_stop: got done=%0b busy=%b red=%0d clear=%0d expected 1 0 50 50",
               got, busy, red, clear);
    end
    const_mode = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_start_while_busy();
    int dones   = 0;
    int late_bad = 0;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        dones++;
        break;
      end
      start = (i == 50 || i == 120 || i == 200);
      tick();
    end
    start = 1'b0;
    tests++;
    if (dones != 1 || red !== 21'd40 || blue !== 21'd60 || green !== 21'd80 || clear !== 21'd20) begin
      fails++;
      $display("FAIL busy_start_results: got done=%0d %0d %0d %0d %0d expected 1 40 60 80 20",
               dones, red, blue, green, clear);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) late_bad++;
      tick();
    end
    tests++;
    if (late_bad != 0) begin
      fails++;
      $display("FAIL busy_start_idle: got %0d cycles busy/done after scan expected 0", late_bad);
    end
  endtask

  task automatic test_reset_mid_measure();
    bit seen = 0;
    bit got;
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      if (busy && {s2, s3} == 2'b01) begin
        seen = 1;
        break;
      end
      tick();
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rst_mid_reach_blue: blue select not seen within 1000 cycles");
    end
    repeat (30) tick();
    #3 rst_n = 1'b0;
    #2;
    tests++;
    if ({busy, done, s0, s1, s2, s3} !== 6'b000000) begin
      fails++;
      $display("FAIL rst_mid_ctrl: got busy/done/s0..s3=%b expected 000000",
               {busy, done, s0, s1, s2, s3});
    end
    tests++;
    if ({red, blue, green, clear} !== '0 || ch_timeout !== 4'b0000) begin
      fails++;
      $display("FAIL rst_mid_results: got %0d %0d %0d %0d to=%b expected all 0",
               red, blue, green, clear, ch_timeout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    clear_log();
    pulse_start();
    wait_done(2000, got);
    tests++;
    if (!got || red !== 21'd40 || blue !== 21'd60 || green !== 21'd80 || clear !== 21'd20
        || ch_timeout !== 4'b0000) begin
      fails++;
      $display("FAIL rst_mid_rescan: got done=%0b %0d %0d %0d %0d to=%b expected 1 40 60 80 20 0000",
               got, red, blue, green, clear, ch_timeout);
    end
    repeat (3) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    sensor_out = 1'b0;
    test_reset();
    test_basic_scan();
    test_pin_sequencing();
    test_timeout();
    test_continuous();
    test_start_while_busy();
    test_reset_mid_measure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
